// File: rtl/unidade_controle_multiciclo.sv
// ---------------------------------------------------------------------------
// unidade_controle_multiciclo
//
// Multicycle control unit. A Moore FSM (FETCH, DECODE, EXEC, MEM, WB,
// WAIT_IN, HALT) drives the datapath strobes. Outputs depend on the
// registered state and on the opcode latched in DECODE. The one exception
// is the conditional-branch pc_write in EXEC, which also uses alu_zero.
//
// Optional feature: define PREEMPCAO_EN to build the retired-instruction
// counter that raises preempt_req every QUANTUM retirements. When the macro
// is not defined, preempt_req is tied low.
//
// Parameters
//   OPCODE_W : opcode width (>= 6; bits above 5 must be zero when valid)
//   QUANTUM  : preemption quantum in retired instructions (>= 2)
//
// Ports
//   clock, reset              : clock and synchronous active-high reset
//   op_code                   : instruction-register opcode, sampled in DECODE
//   alu_zero                  : ALU zero flag, used in EXEC for branches
//   in_valid                  : user-input confirmation, level sensitive
//   pc_write .. preempt_req   : 1-bit control strobes
//   confirma_entrada[1:0]     : write-back source (0 ALU/mem, 1 input, 2 PC)
//   jump_prog[1:0]            : program jump target (0 none, 1 P1, 2 P2)
//   pc_sel[1:0]               : PC source (0 PC+1, 1 branch, 2 jump)
//   state[2:0]                : current FSM state
// ---------------------------------------------------------------------------
module unidade_controle_multiciclo #(
  parameter int OPCODE_W = 6,
  parameter int QUANTUM  = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] op_code,
  input  logic                alu_zero,
  input  logic                in_valid,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                alu_src,
  output logic                alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                print,
  output logic                jump_register,
  output logic                halted,
  output logic                preempt_req,
  output logic [1:0]          confirma_entrada,
  output logic [1:0]          jump_prog,
  output logic [1:0]          pc_sel,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    WAIT_IN = 3'd5,
    HALT    = 3'd6
  } state_t;

  // Opcodes are compared at full width, so nonzero upper bits decode as NOP.
  localparam logic [OPCODE_W-1:0] OP_R      = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ADDI   = OPCODE_W'(6'b000001);
  localparam logic [OPCODE_W-1:0] OP_BEQ    = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_BLEZ   = OPCODE_W'(6'b000011);
  localparam logic [OPCODE_W-1:0] OP_BNE    = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_LW     = OPCODE_W'(6'b000110);
  localparam logic [OPCODE_W-1:0] OP_SW     = OPCODE_W'(6'b000111);
  localparam logic [OPCODE_W-1:0] OP_J      = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_JR     = OPCODE_W'(6'b001010);
  localparam logic [OPCODE_W-1:0] OP_INPUT  = OPCODE_W'(6'b001011);
  localparam logic [OPCODE_W-1:0] OP_OUTPUT = OPCODE_W'(6'b001100);
  localparam logic [OPCODE_W-1:0] OP_P1     = OPCODE_W'(6'b010000);
  localparam logic [OPCODE_W-1:0] OP_P2     = OPCODE_W'(6'b010001);
  localparam logic [OPCODE_W-1:0] OP_RECUP  = OPCODE_W'(6'b010010);
  localparam logic [OPCODE_W-1:0] OP_HALT   = OPCODE_W'(6'b010011);

  state_t                cur_state;
  state_t                next_state;
  logic [OPCODE_W-1:0]   op_q;

  always_comb begin
    next_state = FETCH;
    case (cur_state)
      FETCH:   next_state = DECODE;
      DECODE:  next_state = EXEC;
      EXEC: begin
        if (op_q == OP_LW || op_q == OP_SW)
          next_state = MEM;
        else if (op_q == OP_R || op_q == OP_ADDI || op_q == OP_RECUP)
          next_state = WB;
        else if (op_q == OP_INPUT)
          next_state = WAIT_IN;
        else if (op_q == OP_HALT)
          next_state = HALT;
        else
          next_state = FETCH;
      end
      MEM:     next_state = (op_q == OP_LW) ? WB : FETCH;
      WB:      next_state = FETCH;
      WAIT_IN: next_state = in_valid ? WB : WAIT_IN;
      HALT:    next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_state <= FETCH;
      op_q      <= '0;
    end else begin
      cur_state <= next_state;
      if (cur_state == DECODE)
        op_q <= op_code;
    end
  end

  // A retirement is any entry into FETCH, or the first entry into HALT.
  logic retire;
  assign retire = !reset &&
                  ((next_state == FETCH) ||
                   (next_state == HALT && cur_state != HALT));

`ifdef PREEMPCAO_EN
  localparam int CNT_W = $clog2(QUANTUM);

  logic [CNT_W-1:0] retire_cnt;
  logic             preempt_pend;
  logic             prog_clear;

  // A retiring P1/P2 jump restarts the quantum; this takes priority over
  // counting that retirement.
  assign prog_clear = retire && cur_state == EXEC &&
                      (op_q == OP_P1 || op_q == OP_P2);

  always_ff @(posedge clock) begin
    if (reset) begin
      retire_cnt   <= '0;
      preempt_pend <= 1'b0;
    end else begin
      preempt_pend <= 1'b0;
      if (prog_clear) begin
        retire_cnt <= '0;
      end else if (retire) begin
        if (retire_cnt == CNT_W'(QUANTUM - 1)) begin
          retire_cnt   <= '0;
          preempt_pend <= (next_state == FETCH);
        end else begin
          retire_cnt <= retire_cnt + 1'b1;
        end
      end
    end
  end

  assign preempt_req = preempt_pend && !reset && cur_state == FETCH;
`else
  assign preempt_req = 1'b0;
`endif

  // Output decode. While reset is high every output is forced low, so an
  // interrupted instruction never completes a write strobe.
  always_comb begin
    pc_write         = 1'b0;
    ir_write         = 1'b0;
    reg_write        = 1'b0;
    reg_dst          = 1'b0;
    alu_src          = 1'b0;
    alu_op           = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    mem_to_reg       = 1'b0;
    print            = 1'b0;
    jump_register    = 1'b0;
    halted           = 1'b0;
    confirma_entrada = 2'd0;
    jump_prog        = 2'd0;
    pc_sel           = 2'd0;
    state            = 3'd0;
    if (!reset) begin
      state = cur_state;
      case (cur_state)
        FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
        EXEC: begin
          if (op_q == OP_R) begin
            alu_op  = 1'b1;
            reg_dst = 1'b1;
          end
          if (op_q == OP_ADDI || op_q == OP_LW || op_q == OP_SW)
            alu_src = 1'b1;
          // bgtz is decoded but never takes the branch.
          if ((op_q == OP_BEQ  &&  alu_zero) ||
              (op_q == OP_BNE  && !alu_zero) ||
              (op_q == OP_BLEZ &&  alu_zero)) begin
            pc_write = 1'b1;
            pc_sel   = 2'd1;
          end
          if (op_q == OP_J) begin
            pc_write = 1'b1;
            pc_sel   = 2'd2;
          end
          if (op_q == OP_JR || op_q == OP_P1 || op_q == OP_P2) begin
            pc_write      = 1'b1;
            jump_register = 1'b1;
          end
          if (op_q == OP_P1) jump_prog = 2'd1;
          if (op_q == OP_P2) jump_prog = 2'd2;
          if (op_q == OP_OUTPUT) print = 1'b1;
        end
        MEM: begin
          mem_read  = (op_q == OP_LW);
          mem_write = (op_q == OP_SW);
        end
        WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (op_q == OP_LW);
          reg_dst    = (op_q == OP_R);
          if (op_q == OP_INPUT) confirma_entrada = 2'd1;
          if (op_q == OP_RECUP) confirma_entrada = 2'd2;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
module tb_unidade_controle_multiciclo;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op_code = 6'd0;
  logic       alu_zero = 1'b0;
  logic       in_valid = 1'b0;
  logic pc_write, ir_write, reg_write, reg_dst, alu_src, alu_op, mem_read;
  logic mem_write, mem_to_reg, print, jump_register, halted, preempt_req;
  logic [1:0] confirma_entrada, jump_prog, pc_sel;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  unidade_controle_multiciclo #(.OPCODE_W(6), .QUANTUM(4)) dut (
    .clock(clock), .reset(reset), .op_code(op_code), .alu_zero(alu_zero),
    .in_valid(in_valid), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .print(print), .jump_register(jump_register),
    .halted(halted), .preempt_req(preempt_req),
    .confirma_entrada(confirma_entrada), .jump_prog(jump_prog),
    .pc_sel(pc_sel), .state(state)
  );

  always #5 clock = ~clock;

  // Packed view of all outputs except state.
  logic [18:0] outs;
  assign outs = {pc_write, ir_write, reg_write, reg_dst, alu_src, alu_op,
                 mem_read, mem_write, mem_to_reg, print, jump_register,
                 halted, preempt_req, confirma_entrada, jump_prog, pc_sel};

  localparam logic [18:0] PCW   = 19'h40000;
  localparam logic [18:0] IRW   = 19'h20000;
  localparam logic [18:0] RW    = 19'h10000;
  localparam logic [18:0] RDST  = 19'h08000;
  localparam logic [18:0] ASRC  = 19'h04000;
  localparam logic [18:0] AOP   = 19'h02000;
  localparam logic [18:0] MRD   = 19'h01000;
  localparam logic [18:0] MWR   = 19'h00800;
  localparam logic [18:0] M2R   = 19'h00400;
  localparam logic [18:0] PRT   = 19'h00200;
  localparam logic [18:0] JREG  = 19'h00100;
  localparam logic [18:0] HLT   = 19'h00080;
  localparam logic [18:0] PRE   = 19'h00040;
  localparam logic [18:0] CONF1 = 19'h00010;
  localparam logic [18:0] CONF2 = 19'h00020;
  localparam logic [18:0] JP1   = 19'h00004;
  localparam logic [18:0] JP2   = 19'h00008;
  localparam logic [18:0] SEL1  = 19'h00001;
  localparam logic [18:0] SEL2  = 19'h00002;
  localparam logic [18:0] FOUT  = PCW | IRW;

  // With the preemption counter built, preempt_req is checked only by the
  // dedicated preemption steps; otherwise it must stay low everywhere.
`ifdef PREEMPCAO_EN
  logic [18:0] pmask = ~PRE;
`else
  logic [18:0] pmask = '1;
`endif

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] exp_st,
                     input logic [18:0] exp_o);
    tests++;
    assert (state === exp_st) else begin
      fails++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state, exp_st);
    end
    tests++;
    assert ((outs & pmask) === (exp_o & pmask)) else begin
      fails++;
      $error("FAIL %s outs: observed %05h expected %05h", tag,
             outs & pmask, exp_o & pmask);
    end
  endtask

  task automatic chk_pre(input string tag, input logic exp_p);
    tests++;
    assert (preempt_req === exp_p) else begin
      fails++;
      $error("FAIL %s preempt_req: observed %0b expected %0b", tag,
             preempt_req, exp_p);
    end
  endtask

  // Three-cycle instruction: FETCH, DECODE, EXEC, then back in FETCH.
  task automatic instr3(input string tag, input logic [5:0] op,
                        input logic [18:0] exp_exec);
    op_code = op;
    chk({tag, " F"}, 3'd0, FOUT);
    tick(); chk({tag, " D"}, 3'd1, '0);
    tick(); chk({tag, " E"}, 3'd2, exp_exec);
    tick(); chk({tag, " next"}, 3'd0, FOUT);
  endtask

  // Four-cycle instruction through WB.
  task automatic instr4(input string tag, input logic [5:0] op,
                        input logic [18:0] exp_exec, input logic [18:0] exp_wb);
    op_code = op;
    chk({tag, " F"}, 3'd0, FOUT);
    tick(); chk({tag, " D"}, 3'd1, '0);
    tick(); chk({tag, " E"}, 3'd2, exp_exec);
    tick(); chk({tag, " WB"}, 3'd4, exp_wb);
    tick(); chk({tag, " next"}, 3'd0, FOUT);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("reset held", 3'd0, '0);
    reset = 1'b0;
    #1;

    // lw: states 0,1,2,3,4
    op_code = 6'b000110;
    chk("lw c1", 3'd0, FOUT);
    tick(); chk("lw c2", 3'd1, '0);
    tick(); chk("lw c3", 3'd2, ASRC);
    tick(); chk("lw c4", 3'd3, MRD);
    tick(); chk("lw c5", 3'd4, RW | M2R);
    tick(); chk("lw next", 3'd0, FOUT);

    // Branches
    alu_zero = 1'b1;
    instr3("beq z1", 6'b000010, PCW | SEL1);
    instr3("bne z1", 6'b000100, '0);
    instr3("blez z1", 6'b000011, PCW | SEL1);
    instr3("bgtz z1", 6'b000101, '0);
    alu_zero = 1'b0;
    instr3("bne z0", 6'b000100, PCW | SEL1);
    instr3("beq z0", 6'b000010, '0);

    // Jumps, output, NOP
    instr3("j", 6'b001000, PCW | SEL2);
    instr3("jr", 6'b001010, PCW | JREG);
    instr3("P1", 6'b010000, PCW | JREG | JP1);
    instr3("P2", 6'b010001, PCW | JREG | JP2);
    instr3("output", 6'b001100, PRT);
    instr3("nop", 6'b111111, '0);

    // Four-cycle instructions
    instr4("R", 6'b000000, AOP | RDST, RW | RDST);
    instr4("addi", 6'b000001, ASRC, RW);
    instr4("recup", 6'b010010, '0, RW | CONF2);

    // sw through MEM
    op_code = 6'b000111;
    chk("sw F", 3'd0, FOUT);
    tick(); chk("sw D", 3'd1, '0);
    tick(); chk("sw E", 3'd2, ASRC);
    tick(); chk("sw M", 3'd3, MWR);
    tick(); chk("sw next", 3'd0, FOUT);

    // input with 10 wait cycles
    op_code = 6'b001011;
    in_valid = 1'b0;
    chk("in F", 3'd0, FOUT);
    tick(); chk("in D", 3'd1, '0);
    tick(); chk("in E", 3'd2, '0);
    for (int i = 0; i < 10; i++) begin
      tick(); chk($sformatf("in wait%0d", i), 3'd5, '0);
    end
    in_valid = 1'b1;
    tick(); chk("in WB", 3'd4, RW | CONF1);
    in_valid = 1'b0;
    tick(); chk("in next", 3'd0, FOUT);

    // Reset during MEM of sw
    op_code = 6'b000111;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("sw rst in MEM", 3'd0, '0);
    tick(); chk("sw rst after", 3'd0, '0);
    reset = 1'b0;
    #1;
    chk("sw rst release", 3'd0, FOUT);

    // Reset during WAIT_IN with in_valid high
    op_code = 6'b001011;
    tick(); tick(); tick();
    chk("in2 wait", 3'd5, '0);
    in_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk("in2 rst in WAIT", 3'd0, '0);
    tick(); chk("in2 rst after", 3'd0, '0);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("in2 rst release", 3'd0, FOUT);

    // halt held 20 cycles, then reset
    op_code = 6'b010011;
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      tick(); chk($sformatf("halt%0d", i), 3'd6, HLT);
    end
    reset = 1'b1;
    tick(); chk("halt rst", 3'd0, '0);
    reset = 1'b0;
    #1;
    chk("halt release", 3'd0, FOUT);

`ifdef PREEMPCAO_EN
    // Five addi with QUANTUM=4: single pulse in FETCH after the fourth.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      op_code = 6'b000001;
      chk_pre($sformatf("q addi%0d F", i), (i == 4));
      tick(); tick(); tick(); tick();
    end
    // addi, addi, P1, then four addi: pulse only after the fourth addi.
    do_reset();
    op_code = 6'b000001;
    chk_pre("c addi0 F", 1'b0);
    tick(); tick(); tick(); tick();
    chk_pre("c addi1 F", 1'b0);
    tick(); tick(); tick(); tick();
    op_code = 6'b010000;
    chk_pre("c P1 F", 1'b0);
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      op_code = 6'b000001;
      chk_pre($sformatf("c after P1 %0d F", i), (i == 4));
      tick(); tick(); tick(); tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
